// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: grants the shared data-memory port to one of four cores per cycle,
// drives per-core stall stages and steers delayed read data back to the requesting core.
module core_mem_arbiter #(
  parameter int unsigned RD_LAT     = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awake,
  input  logic [3:0]  ld_req,
  input  logic [59:0] ld_addr,
  input  logic [3:0]  st_req,
  input  logic [59:0] st_addr,
  input  logic [63:0] st_data,
  output logic [11:0] stall_num,
  output logic [71:0] rdata,
  output logic        mem_ren,
  output logic [14:0] mem_raddr,
  output logic        mem_wen,
  output logic [14:0] mem_waddr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);
  logic [3:0] w_l, w_s, w_req;
  logic       w_ld_cls, w_st_cls;
  logic [1:0] w_ptr, w_win;
  logic [1:0] r_st_ptr, r_ld_ptr;
  logic [2:0] r_starve;
  logic       r_vld [RD_LAT];
  logic [1:0] r_id  [RD_LAT];

  assign w_l      = ld_req & awake;
  assign w_s      = st_req & awake;
  // Stores normally win; loads take over once they have lost STARVE_MAX cycles in a row
  assign w_ld_cls = (|w_l) && (~|w_s || 32'(r_starve) >= STARVE_MAX);
  assign w_st_cls = (|w_s) && !w_ld_cls;
  assign w_req    = w_ld_cls ? w_l : w_s;
  assign w_ptr    = w_ld_cls ? r_ld_ptr : r_st_ptr;
  assign mem_ren  = rst_n & w_ld_cls;
  assign mem_wen  = rst_n & w_st_cls;

  always_comb begin
    w_win = w_ptr;
    for (int i = 3; i >= 0; i--)
      if (w_req[w_ptr + 2'(i)]) w_win = w_ptr + 2'(i);
  end

  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    stall_num = '0;
    rdata     = '0;
    for (int n = 0; n < 4; n++) begin
      if (w_win == 2'(n)) begin
        mem_raddr = ld_addr[15*n +: 15];
        mem_waddr = st_addr[15*n +: 15];
        mem_wdata = st_data[16*n +: 16];
      end
      if (rst_n && !((w_ld_cls || w_st_cls) && w_win == 2'(n)))
        stall_num[3*n +: 3] = w_s[n] ? 3'd6 : w_l[n] ? 3'd3 : 3'd0;
      if (rst_n && r_vld[RD_LAT-1] && r_id[RD_LAT-1] == 2'(n))
        rdata[18*n +: 18] = {2'b10, mem_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_ptr <= '0;
      r_ld_ptr <= '0;
      r_starve <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_vld[i] <= 1'b0;
        r_id[i]  <= '0;
      end
    end else begin
      if (w_st_cls) r_st_ptr <= w_win + 2'd1;
      if (w_ld_cls) r_ld_ptr <= w_win + 2'd1;
      r_starve <= (w_ld_cls || ~|w_l) ? 3'd0 : (r_starve == 3'd7) ? r_starve : r_starve + 3'd1;
      r_vld[0] <= w_ld_cls;
      r_id[0]  <= w_win;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the arbitration rules.
module tb_core_mem_arbiter;
  localparam int RD_LAT = 3;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awake = '0, ld_req = '0, st_req = '0;
  logic [59:0] ld_addr = '0, st_addr = '0;
  logic [63:0] st_data = '0;
  logic [15:0] mem_rdata = '0;
  logic [11:0] stall_num;
  logic [71:0] rdata;
  logic        mem_ren, mem_wen;
  logic [14:0] mem_raddr, mem_waddr;
  logic [15:0] mem_wdata;

  core_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .awake(awake), .ld_req(ld_req), .ld_addr(ld_addr),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .stall_num(stall_num),
    .rdata(rdata), .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {int due; int core;} ret_t;
  ret_t rq[$];
  int m_st_ptr = 0, m_ld_ptr = 0, m_starve = 0, cyc = 0;
  logic        e_ren, e_wen;
  logic [14:0] e_raddr, e_waddr;
  logic [15:0] e_wdata;
  logic [11:0] e_stall;
  logic [71:0] e_rdata;
  int          e_win;

  function automatic void model_eval();
    logic [3:0] l, s, req;
    int ptr;
    bit ld;
    l = ld_req & awake;
    s = st_req & awake;
    e_ren = 0; e_wen = 0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
    e_stall = '0; e_rdata = '0; e_win = -1;
    if (rst_n !== 1'b1) return;
    ld = (l != 0) && (s == 0 || m_starve >= STARVE_MAX);
    if (ld || s != 0) begin
      req = ld ? l : s;
      ptr = ld ? m_ld_ptr : m_st_ptr;
      for (int k = 0; k < 4; k++)
        if (e_win < 0 && req[(ptr + k) % 4]) e_win = (ptr + k) % 4;
      if (ld) begin
        e_ren = 1; e_raddr = ld_addr[15*e_win +: 15];
      end else begin
        e_wen = 1; e_waddr = st_addr[15*e_win +: 15]; e_wdata = st_data[16*e_win +: 16];
      end
    end
    for (int c = 0; c < 4; c++)
      e_stall[3*c +: 3] = (c == e_win) ? 3'd0 : s[c] ? 3'd6 : l[c] ? 3'd3 : 3'd0;
    if (rq.size() > 0 && rq[0].due == cyc) e_rdata[18*rq[0].core +: 18] = {2'b10, mem_rdata};
  endfunction

  function automatic void model_commit();
    logic [3:0] l;
    if (rst_n !== 1'b1) begin
      m_st_ptr = 0; m_ld_ptr = 0; m_starve = 0; rq.delete(); cyc++;
      return;
    end
    l = ld_req & awake;
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (e_wen) m_st_ptr = (e_win + 1) % 4;
    if (e_ren) begin
      m_ld_ptr = (e_win + 1) % 4;
      rq.push_back('{cyc + RD_LAT, e_win});
    end
    m_starve = (e_ren || l == 0) ? 0 : (m_starve < 7 ? m_starve + 1 : 7);
    cyc++;
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clock();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; awake = '0; ld_req = '0; st_req = '0; mem_rdata = '0;
    sample(); clock();
    sample(); clock();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; awake = 4'hF; ld_req = 4'hF; st_req = 4'h5; mem_rdata = 16'hA5A5;
    sample();
    n_tests++;
    if ({mem_ren, mem_wen, stall_num, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ren=%b wen=%b stall=%h rdata=%h, want all 0", mem_ren, mem_wen, stall_num, rdata);
    end
    clock();
    do_reset();
    awake = 4'hF; ld_req = 4'b0100; ld_addr[30 +: 15] = 15'h0040;
    sample();
    n_tests++;
    if (mem_ren !== 1'b1) begin n_fail++; $display("FAIL reset_midload_grant: ren=%b want 1", mem_ren); end
    clock();
    ld_req = '0; rst_n = 1'b0;
    sample();
    n_tests++;
    if ({mem_ren, mem_wen, stall_num, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_midload_during: ren=%b wen=%b stall=%h rdata=%h, want all 0", mem_ren, mem_wen, stall_num, rdata);
    end
    clock();
    rst_n = 1'b1;
    sample(); clock();
    mem_rdata = 16'hBEEF;
    sample();
    n_tests++;
    if (rdata !== '0) begin n_fail++; $display("FAIL reset_midload_drop: rdata=%h want 0", rdata); end
    clock();
  endtask

  task automatic test_single_load();
    do_reset();
    awake = 4'hF; ld_req = 4'b0100; ld_addr[30 +: 15] = 15'h0040;
    sample();
    n_tests++;
    if ({mem_ren, mem_wen, mem_raddr, stall_num[8:6]} !== {1'b1, 1'b0, 15'h0040, 3'd0}) begin
      n_fail++;
      $display("FAIL single_load_grant: ren=%b wen=%b raddr=%h stall2=%0d want 1 0 0040 0", mem_ren, mem_wen, mem_raddr, stall_num[8:6]);
    end
    clock();
    ld_req = '0;
    for (int k = 1; k <= 4; k++) begin
      mem_rdata = (k == 3) ? 16'hBEEF : 16'h1111;
      sample();
      n_tests++;
      if (rdata !== ((k == 3) ? {18'h0, 18'h2BEEF, 36'h0} : 72'h0)) begin
        n_fail++;
        $display("FAIL single_load_return_c%0d: rdata=%h want core2=%h", k, rdata, (k == 3) ? 18'h2BEEF : 18'h0);
      end
      clock();
    end
  endtask

  task automatic test_store_vs_load();
    do_reset();
    awake = 4'hF; ld_req = 4'b0001; ld_addr[0 +: 15] = 15'h0123;
    st_req = 4'b0010; st_addr[15 +: 15] = 15'h0010; st_data[16 +: 16] = 16'h1234;
    sample();
    n_tests++;
    if ({mem_wen, mem_ren, mem_waddr, mem_wdata, stall_num[2:0], stall_num[5:3]} !==
        {1'b1, 1'b0, 15'h0010, 16'h1234, 3'd3, 3'd0}) begin
      n_fail++;
      $display("FAIL store_vs_load_store: wen=%b ren=%b waddr=%h wdata=%h stall0=%0d stall1=%0d want 1 0 0010 1234 3 0",
               mem_wen, mem_ren, mem_waddr, mem_wdata, stall_num[2:0], stall_num[5:3]);
    end
    clock();
    st_req = '0;
    sample();
    n_tests++;
    if ({mem_ren, mem_wen, mem_raddr, stall_num[2:0]} !== {1'b1, 1'b0, 15'h0123, 3'd0}) begin
      n_fail++;
      $display("FAIL store_vs_load_next: ren=%b wen=%b raddr=%h stall0=%0d want 1 0 0123 0", mem_ren, mem_wen, mem_raddr, stall_num[2:0]);
    end
    clock();
    ld_req = '0;
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_stall;
    do_reset();
    awake = 4'hF; st_req = 4'hF;
    for (int n = 0; n < 4; n++) begin
      st_addr[15*n +: 15] = 15'(16'h100 + n);
      st_data[16*n +: 16] = 16'(16'hD000 + n);
    end
    for (int k = 0; k < 5; k++) begin
      sample();
      exp_stall = '0;
      for (int c = 0; c < 4; c++) if (c != k % 4) exp_stall[3*c +: 3] = 3'd6;
      n_tests++;
      if ({mem_wen, mem_waddr, mem_wdata, stall_num} !== {1'b1, 15'(16'h100 + k % 4), 16'(16'hD000 + k % 4), exp_stall}) begin
        n_fail++;
        $display("FAIL round_robin_c%0d: wen=%b waddr=%h wdata=%h stall=%h want winner %0d stall=%h",
                 k, mem_wen, mem_waddr, mem_wdata, stall_num, k % 4, exp_stall);
      end
      clock();
    end
    st_req = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    awake = 4'hF; st_req = 4'hF; ld_req = 4'b0010; ld_addr[15 +: 15] = 15'h0222;
    for (int n = 0; n < 4; n++) st_addr[15*n +: 15] = 15'(16'h100 + n);
    for (int k = 0; k < 10; k++) begin
      sample();
      n_tests++;
      if (k == 4 || k == 9) begin
        if ({mem_ren, mem_wen, mem_raddr, stall_num[2:0]} !== {1'b1, 1'b0, 15'h0222, 3'd6}) begin
          n_fail++;
          $display("FAIL starve_load_c%0d: ren=%b wen=%b raddr=%h stall0=%0d want 1 0 0222 6", k, mem_ren, mem_wen, mem_raddr, stall_num[2:0]);
        end
      end else begin
        if ({mem_wen, mem_ren, mem_waddr, stall_num[5:3] == 3'd6 || k % 5 == 1} !==
            {1'b1, 1'b0, 15'(16'h100 + k % 5), 1'b1}) begin
          n_fail++;
          $display("FAIL starve_store_c%0d: wen=%b ren=%b waddr=%h stall1=%0d want 1 0 %h", k, mem_wen, mem_ren, mem_waddr, stall_num[5:3], 16'h100 + k % 5);
        end
      end
      clock();
    end
    st_req = '0; ld_req = '0;
  endtask

  task automatic test_asleep();
    do_reset();
    awake = 4'b1110; ld_req = 4'b0001;
    sample();
    n_tests++;
    if ({mem_ren, mem_wen, stall_num[2:0]} !== {1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL asleep_load: ren=%b wen=%b stall0=%0d want 0 0 0", mem_ren, mem_wen, stall_num[2:0]);
    end
    clock();
    ld_req = '0; awake = 4'hF; st_req = 4'b0011;
    st_addr[0 +: 15] = 15'h0AAA; st_addr[15 +: 15] = 15'h0BBB;
    sample();
    n_tests++;
    if ({mem_waddr, stall_num[5:3]} !== {15'h0AAA, 3'd6}) begin
      n_fail++;
      $display("FAIL asleep_pre: waddr=%h stall1=%0d want 0AAA 6", mem_waddr, stall_num[5:3]);
    end
    clock();
    awake = 4'b1101;
    sample();
    n_tests++;
    if ({mem_wen, mem_waddr, stall_num[5:3]} !== {1'b1, 15'h0AAA, 3'd0}) begin
      n_fail++;
      $display("FAIL asleep_fall: wen=%b waddr=%h stall1=%0d want 1 0AAA 0", mem_wen, mem_waddr, stall_num[5:3]);
    end
    clock();
    st_req = '0; awake = 4'hF;
  endtask

  task automatic test_back_to_back();
    int r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      awake = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      ld_req = '0; st_req = '0;
      for (int c = 0; c < 4; c++) begin
        r = $urandom_range(0, 4);
        if (r == 1 || r == 2) ld_req[c] = 1'b1;
        if (r == 3) st_req[c] = 1'b1;
      end
      ld_addr = 60'({$urandom, $urandom});
      st_addr = 60'({$urandom, $urandom});
      st_data = {$urandom, $urandom};
      mem_rdata = 16'($urandom);
      sample();
      n_tests++;
      if ({mem_ren, mem_wen} !== {e_ren, e_wen} || (e_ren && mem_raddr !== e_raddr) ||
          (e_wen && {mem_waddr, mem_wdata} !== {e_waddr, e_wdata})) begin
        n_fail++;
        $display("FAIL rand_req_c%0d: ren=%b wen=%b raddr=%h waddr=%h wdata=%h want %b %b %h %h %h",
                 k, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, e_ren, e_wen, e_raddr, e_waddr, e_wdata);
      end
      n_tests++;
      if (stall_num !== e_stall) begin
        n_fail++;
        $display("FAIL rand_stall_c%0d: stall=%h want %h", k, stall_num, e_stall);
      end
      n_tests++;
      if (rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL rand_rdata_c%0d: rdata=%h want %h", k, rdata, e_rdata);
      end
      clock();
    end
    ld_req = '0; st_req = '0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_load();
    test_store_vs_load();
    test_round_robin();
    test_starvation();
    test_asleep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
